nbuf_frame_ctrl: RTL and testbench
==================================

// Module: nbuf_frame_ctrl
// PURPOSE
//  Parametrised N-buffer frame rotation controller; successor to the fixed 3-SRAM select controller.
//  Tracks NUM_BUF frame buffers as FREE/WRITING/READY/READING and drives write/read buffer indices to the mem/data/ready muxes.
//  Capture side and display side are both advanced by vsync-type triggers.
//  Adds a latest-frame (drop) mode, an in-order queue mode, drop/repeat statistics and an enable gate.
// PARAMETERS
//  NUM_BUF      3   number of frame buffers, legal 3..8
//  SEL_W        3   index width, >= clog2(NUM_BUF)
//  CNT_W        16  width of statistic counters
//  SYNC_STAGES  2   synchroniser flops per trigger input, >= 2
// PORTS
//  clk                   in   1      system clock (50 MHz)
//  reset                 in   1      asynchronous, active-low reset
//  enable                in   1      1 = act on events; 0 = events discarded, state held
//  mode                  in   1      0 = latest-frame, 1 = queue
//  capture_trigger       in   1      camera vsync, async; rising edge = capture frame complete
//  transmission_trigger  in   1      VGA vsync, async; rising edge = display frame boundary
//  write_sel             out  SEL_W  buffer index the capture path writes
//  read_sel              out  SEL_W  buffer index the display path reads
//  wr_swap               out  1      1-cycle pulse, write_sel updated this cycle
//  rd_swap               out  1      1-cycle pulse, read_sel updated this cycle
//  ready_count           out  4      buffers in READY state
//  frames_dropped        out  CNT_W  saturating count of discarded captured frames
//  frames_repeated       out  CNT_W  saturating count of display events with no new frame
// BEHAVIOUR
//  Reset (async assert, sync release):
//   write_sel=0 (WRITING), read_sel=1 (READING), buffers 2..NUM_BUF-1 FREE, ready queue empty.
//   Pulses, ready_count and counters all 0.
//  Trigger path:
//   Each trigger passes through SYNC_STAGES flops plus one delay flop; event = sync_last & ~delay.
//   Outputs are registered and update SYNC_STAGES+1 clk edges after the first edge that samples the trigger high.
//   A level held high produces exactly one event.
//  Invariants:
//   Exactly one WRITING buffer and one READING buffer; write_sel != read_sel at all times.
//   READY buffers sit in an ordered queue, capacity NUM_BUF-2.
//  Capture event, mode=0 (latest):
//   Current write buffer -> READY, becomes sole queue entry.
//   Any previously READY buffers -> FREE; frames_dropped += count freed.
//   New write_sel = lowest-index FREE buffer; wr_swap=1.
//  Capture event, mode=1 (queue):
//   Queue not full: write buffer appended to queue tail; write_sel = lowest-index FREE; wr_swap=1.
//   Queue full: write_sel unchanged (frame overwritten in place); frames_dropped += 1; wr_swap=0.
//  Display event:
//   Queue non-empty: old read buffer -> FREE; read_sel = head (mode 1) or newest entry (mode 0); rd_swap=1.
//   In mode 0, any other READY entries -> FREE and count as dropped.
//   Queue empty: read_sel held; frames_repeated += 1; rd_swap=0.
//  Simultaneous events, same cycle:
//   Display processed first; capture then sees the updated queue and free set.
//   The buffer just freed by display may be chosen as the new write_sel.
//  Mode change:
//   Sampled only at events; no state change on the toggle itself.
//   Queue->latest with several READY entries: they are collapsed at the next event.
//  enable=0:
//   Events detected and discarded; sync/delay flops keep running so no stale edge fires on re-enable.
//  Counters saturate at 2^CNT_W-1; they never wrap.
//  ready_count is updated in the same cycle as the swap pulses.
// TESTING
//  1 Reset mid-frame with trigger high -> write_sel=0, read_sel=1, counters 0, no event until trigger falls and rises again.
//  2 NUM_BUF=3, mode 0, captures C,C,C with no display -> write_sel 0->2->0->2, frames_dropped=2, ready_count=1.
//  3 NUM_BUF=4, mode 1, captures on buffers 0,2,3; queue capacity 2; 3rd capture -> write_sel held, dropped=1;
//    next 2 displays -> read_sel 0 then 2.
//  4 Capture and display edges in the same clk cycle, NUM_BUF=3 after 1 capture -> read_sel=0, write_sel=1,
//    both pulses high, no drop/repeat.
//  5 Three display events with no capture -> read_sel stays 1, frames_repeated=3, rd_swap never high.
//  6 enable=0 over 5 capture edges, then enable=1 -> no state change, no spurious event; CNT_W=2 saturation holds at 3.

Source files
------------

// File: rtl/nbuf_frame_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : nbuf_frame_ctrl
// Purpose  : N-buffer frame rotation controller. Tracks NUM_BUF frame
//            buffers (FREE / WRITING / READY / READING), keeps READY buffers
//            in an ordered queue and drives the capture/display buffer
//            indices. Supports latest-frame and in-order queue modes with
//            saturating drop/repeat statistics and an enable gate.
// Revision : 1.0 - initial release
// ============================================================================
module nbuf_frame_ctrl #(
    parameter int NUM_BUF     = 3,
    parameter int SEL_W       = 3,
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             mode,
    input  logic             capture_trigger,
    input  logic             transmission_trigger,
    output logic [SEL_W-1:0] write_sel,
    output logic [SEL_W-1:0] read_sel,
    output logic             wr_swap,
    output logic             rd_swap,
    output logic [3:0]       ready_count,
    output logic [CNT_W-1:0] frames_dropped,
    output logic [CNT_W-1:0] frames_repeated
);

    localparam int             c_QCAP    = NUM_BUF - 2;
    localparam int             c_SUM_W   = CNT_W + 4;
    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

    // Synchroniser chains plus edge-delay flops
    logic [SYNC_STAGES-1:0] r_cap_sync;
    logic [SYNC_STAGES-1:0] r_disp_sync;
    logic                   r_cap_dly;
    logic                   r_disp_dly;

    // Buffer ownership state
    logic [SEL_W-1:0] r_wr_sel;
    logic [SEL_W-1:0] r_rd_sel;
    logic [SEL_W-1:0] r_queue [c_QCAP];
    logic [3:0]       r_qcnt;
    logic             r_wr_swap;
    logic             r_rd_swap;
    logic [CNT_W-1:0] r_dropped;
    logic [CNT_W-1:0] r_repeated;

    // Next-state wires
    logic             w_cap_go;
    logic             w_disp_go;
    logic [SEL_W-1:0] w_wr;
    logic [SEL_W-1:0] w_rd;
    logic [SEL_W-1:0] w_q [c_QCAP];
    logic [3:0]       w_qcnt;
    logic             w_wr_swap;
    logic             w_rd_swap;
    logic [3:0]       w_drop_inc;
    logic             w_rep_inc;
    logic             w_used;
    logic [c_SUM_W-1:0] w_drop_sum;
    logic [c_SUM_W-1:0] w_rep_sum;
    logic [CNT_W-1:0] w_dropped;
    logic [CNT_W-1:0] w_repeated;

    // Trigger synchronisers; reset to all-ones so a trigger already high at
    // reset release is treated as old and needs a fresh rising edge to fire
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cap_sync  <= {SYNC_STAGES{1'b1}};
            r_disp_sync <= {SYNC_STAGES{1'b1}};
            r_cap_dly   <= 1'b1;
            r_disp_dly  <= 1'b1;
        end else begin
            r_cap_sync  <= {r_cap_sync[SYNC_STAGES-2:0], capture_trigger};
            r_disp_sync <= {r_disp_sync[SYNC_STAGES-2:0], transmission_trigger};
            r_cap_dly   <= r_cap_sync[SYNC_STAGES-1];
            r_disp_dly  <= r_disp_sync[SYNC_STAGES-1];
        end
    end

    // Events are detected continuously but only acted on while enabled
    assign w_cap_go  = enable & r_cap_sync[SYNC_STAGES-1]  & ~r_cap_dly;
    assign w_disp_go = enable & r_disp_sync[SYNC_STAGES-1] & ~r_disp_dly;

    // Buffer rotation: display is resolved first, capture then sees the result
    always_comb begin
        w_q        = r_queue;
        w_qcnt     = r_qcnt;
        w_rd       = r_rd_sel;
        w_wr       = r_wr_sel;
        w_drop_inc = 4'd0;
        w_rep_inc  = 1'b0;
        w_wr_swap  = 1'b0;
        w_rd_swap  = 1'b0;
        w_used     = 1'b0;

        if (w_disp_go) begin
            if (w_qcnt != 4'd0) begin
                w_rd_swap = 1'b1;
                if (mode) begin
                    // Queue mode: pop the oldest entry
                    w_rd = w_q[0];
                    for (int k = 0; k < c_QCAP - 1; k++) begin
                        w_q[k] = w_q[k+1];
                    end
                    w_qcnt = w_qcnt - 4'd1;
                end else begin
                    // Latest mode: take the newest, discard the rest
                    for (int k = 0; k < c_QCAP; k++) begin
                        if (4'(k) == w_qcnt - 4'd1) begin
                            w_rd = w_q[k];
                        end
                    end
                    w_drop_inc = w_qcnt - 4'd1;
                    w_qcnt     = 4'd0;
                end
            end else begin
                w_rep_inc = 1'b1;
            end
        end

        if (w_cap_go) begin
            if (!mode) begin
                w_drop_inc = w_drop_inc + w_qcnt;
                w_q[0]     = r_wr_sel;
                w_qcnt     = 4'd1;
                w_wr_swap  = 1'b1;
            end else if (w_qcnt < 4'(c_QCAP)) begin
                for (int k = 0; k < c_QCAP; k++) begin
                    if (4'(k) == w_qcnt) begin
                        w_q[k] = r_wr_sel;
                    end
                end
                w_qcnt    = w_qcnt + 4'd1;
                w_wr_swap = 1'b1;
            end else begin
                // Queue full: the current write buffer is overwritten in place
                w_drop_inc = w_drop_inc + 4'd1;
            end

            // Lowest-index FREE buffer; scanning downward lets the lowest win.
            // The old write buffer is already queued, so it is never chosen.
            if (w_wr_swap) begin
                for (int i = NUM_BUF - 1; i >= 0; i--) begin
                    w_used = (SEL_W'(i) == w_rd) || (SEL_W'(i) == r_wr_sel);
                    for (int k = 0; k < c_QCAP; k++) begin
                        if ((4'(k) < w_qcnt) && (w_q[k] == SEL_W'(i))) begin
                            w_used = 1'b1;
                        end
                    end
                    if (!w_used) begin
                        w_wr = SEL_W'(i);
                    end
                end
            end
        end
    end

    // Saturating statistic counters
    always_comb begin
        w_drop_sum = c_SUM_W'(r_dropped) + c_SUM_W'(w_drop_inc);
        w_rep_sum  = c_SUM_W'(r_repeated) + c_SUM_W'(w_rep_inc);
        w_dropped  = (w_drop_sum > c_SUM_W'(c_CNT_MAX)) ? c_CNT_MAX : w_drop_sum[CNT_W-1:0];
        w_repeated = (w_rep_sum  > c_SUM_W'(c_CNT_MAX)) ? c_CNT_MAX : w_rep_sum[CNT_W-1:0];
    end

    // Registered buffer state, pulses and statistics
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_sel   <= SEL_W'(0);
            r_rd_sel   <= SEL_W'(1);
            for (int k = 0; k < c_QCAP; k++) begin
                r_queue[k] <= SEL_W'(0);
            end
            r_qcnt     <= 4'd0;
            r_wr_swap  <= 1'b0;
            r_rd_swap  <= 1'b0;
            r_dropped  <= {CNT_W{1'b0}};
            r_repeated <= {CNT_W{1'b0}};
        end else begin
            r_wr_sel   <= w_wr;
            r_rd_sel   <= w_rd;
            r_queue    <= w_q;
            r_qcnt     <= w_qcnt;
            r_wr_swap  <= w_wr_swap;
            r_rd_swap  <= w_rd_swap;
            r_dropped  <= w_dropped;
            r_repeated <= w_repeated;
        end
    end

    assign write_sel       = r_wr_sel;
    assign read_sel        = r_rd_sel;
    assign wr_swap         = r_wr_swap;
    assign rd_swap         = r_rd_swap;
    assign ready_count     = r_qcnt;
    assign frames_dropped  = r_dropped;
    assign frames_repeated = r_repeated;

endmodule
`default_nettype wire

// File: tb/tb_nbuf_frame_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_nbuf_frame_ctrl
// Purpose  : Directed self-checking bench for nbuf_frame_ctrl. Instance A is
//            NUM_BUF=3 / CNT_W=2, instance B is NUM_BUF=4 / CNT_W=16.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nbuf_frame_ctrl;

    logic clk = 1'b0;
    logic reset;
    logic en_a, mode_a, cap_a, disp_a;
    logic en_b, mode_b, cap_b, disp_b;

    logic [2:0]  wr_a, rd_a, wr_b, rd_b;
    logic        wsw_a, rsw_a, wsw_b, rsw_b;
    logic [3:0]  rc_a, rc_b;
    logic [1:0]  drop_a, rep_a;
    logic [15:0] drop_b, rep_b;

    int checks   = 0;
    int failures = 0;
    int wcnt_a   = 0;
    int rcnt_a   = 0;
    int base_w, base_r;
    logic pre_wa, snap_wa, snap_ra, snap_wb, snap_rb;

    always #5 clk = ~clk;

    nbuf_frame_ctrl #(.NUM_BUF(3), .SEL_W(3), .CNT_W(2), .SYNC_STAGES(2)) u_dut_a (
        .clk(clk), .reset(reset), .enable(en_a), .mode(mode_a),
        .capture_trigger(cap_a), .transmission_trigger(disp_a),
        .write_sel(wr_a), .read_sel(rd_a), .wr_swap(wsw_a), .rd_swap(rsw_a),
        .ready_count(rc_a), .frames_dropped(drop_a), .frames_repeated(rep_a)
    );

    nbuf_frame_ctrl #(.NUM_BUF(4), .SEL_W(3), .CNT_W(16), .SYNC_STAGES(2)) u_dut_b (
        .clk(clk), .reset(reset), .enable(en_b), .mode(mode_b),
        .capture_trigger(cap_b), .transmission_trigger(disp_b),
        .write_sel(wr_b), .read_sel(rd_b), .wr_swap(wsw_b), .rd_swap(rsw_b),
        .ready_count(rc_b), .frames_dropped(drop_b), .frames_repeated(rep_b)
    );

    // Pulse counters for instance A, sampled away from the active edge
    always @(negedge clk) begin
        if (wsw_a === 1'b1) wcnt_a++;
        if (rsw_a === 1'b1) rcnt_a++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Raise the chosen triggers, snapshot pulses one edge before and at the
    // expected update edge, then drop the triggers and let the chain settle
    task automatic fire(input logic ca, input logic da, input logic cb, input logic db);
        @(negedge clk);
        cap_a = ca; disp_a = da; cap_b = cb; disp_b = db;
        repeat (2) @(posedge clk);
        #1;
        pre_wa = wsw_a;
        @(posedge clk);
        #1;
        snap_wa = wsw_a; snap_ra = rsw_a; snap_wb = wsw_b; snap_rb = rsw_b;
        @(negedge clk);
        cap_a = 1'b0; disp_a = 1'b0; cap_b = 1'b0; disp_b = 1'b0;
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        en_a = 1'b1; mode_a = 1'b0; cap_a = 1'b0; disp_a = 1'b0;
        en_b = 1'b1; mode_b = 1'b1; cap_b = 1'b0; disp_b = 1'b0;
        pre_wa = 1'b0; snap_wa = 1'b0; snap_ra = 1'b0; snap_wb = 1'b0; snap_rb = 1'b0;
        do_reset();

        // Reset state
        chk("rst_wr",   32'(wr_a),   0);
        chk("rst_rd",   32'(rd_a),   1);
        chk("rst_rc",   32'(rc_a),   0);
        chk("rst_drop", 32'(drop_a), 0);
        chk("rst_rep",  32'(rep_a),  0);
        chk("rst_wsw",  32'(wsw_a),  0);
        chk("rst_rsw",  32'(rsw_a),  0);

        // Latest mode, three captures with no display
        base_w = wcnt_a;
        fire(1, 0, 0, 0);
        chk("lat_early", 32'(pre_wa),  0);
        chk("lat_pulse", 32'(snap_wa), 1);
        chk("c1_wr",     32'(wr_a),    2);
        fire(1, 0, 0, 0);
        chk("c2_wr",     32'(wr_a),    0);
        fire(1, 0, 0, 0);
        chk("c3_wr",     32'(wr_a),    2);
        chk("c3_drop",   32'(drop_a),  2);
        chk("c3_rc",     32'(rc_a),    1);
        chk("c3_wpulses", 32'(wcnt_a - base_w), 3);

        // Held trigger fires once, then reset mid-frame with it still high
        @(negedge clk);
        cap_a = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("hold_wr",   32'(wr_a),   0);
        chk("hold_drop", 32'(drop_a), 3);
        do_reset();
        repeat (10) @(posedge clk);
        #1;
        chk("mid_wr",   32'(wr_a),   0);
        chk("mid_rd",   32'(rd_a),   1);
        chk("mid_drop", 32'(drop_a), 0);
        chk("mid_rc",   32'(rc_a),   0);
        base_w = wcnt_a;
        @(negedge clk);
        cap_a = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("mid_noev", 32'(wcnt_a - base_w), 0);
        fire(1, 0, 0, 0);
        chk("mid_rearm_wr", 32'(wr_a), 2);

        // Dropped counter saturates at 3
        repeat (4) fire(1, 0, 0, 0);
        chk("sat_drop", 32'(drop_a), 3);
        chk("sat_wr",   32'(wr_a),   2);

        // Displays with nothing ready
        do_reset();
        base_r = rcnt_a;
        repeat (3) fire(0, 1, 0, 0);
        chk("rep_rd",     32'(rd_a), 1);
        chk("rep_cnt",    32'(rep_a), 3);
        chk("rep_pulses", 32'(rcnt_a - base_r), 0);
        fire(0, 1, 0, 0);
        chk("rep_sat",    32'(rep_a), 3);

        // Simultaneous capture and display after one capture
        do_reset();
        fire(1, 0, 0, 0);
        chk("sim_pre_wr", 32'(wr_a), 2);
        fire(1, 1, 0, 0);
        chk("sim_wsw",  32'(snap_wa), 1);
        chk("sim_rsw",  32'(snap_ra), 1);
        chk("sim_rd",   32'(rd_a),    0);
        chk("sim_wr",   32'(wr_a),    1);
        chk("sim_drop", 32'(drop_a),  0);
        chk("sim_rep",  32'(rep_a),   0);
        chk("sim_rc",   32'(rc_a),    1);

        // Enable gate
        @(negedge clk);
        en_a = 1'b0;
        base_w = wcnt_a;
        repeat (5) fire(1, 0, 0, 0);
        chk("dis_wr",     32'(wr_a), 1);
        chk("dis_rd",     32'(rd_a), 0);
        chk("dis_rc",     32'(rc_a), 1);
        chk("dis_pulses", 32'(wcnt_a - base_w), 0);
        @(negedge clk);
        en_a = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("reen_noev", 32'(wcnt_a - base_w), 0);
        chk("reen_wr",   32'(wr_a), 1);
        fire(1, 0, 0, 0);
        chk("reen_cap_wr",   32'(wr_a),   2);
        chk("reen_cap_drop", 32'(drop_a), 1);

        // Queue mode on four buffers
        do_reset();
        fire(0, 0, 1, 0);
        chk("q1_wr", 32'(wr_b), 2);
        chk("q1_rc", 32'(rc_b), 1);
        fire(0, 0, 1, 0);
        chk("q2_wr", 32'(wr_b), 3);
        chk("q2_rc", 32'(rc_b), 2);
        fire(0, 0, 1, 0);
        chk("q3_wr",   32'(wr_b),    3);
        chk("q3_drop", 32'(drop_b),  1);
        chk("q3_wsw",  32'(snap_wb), 0);
        fire(0, 0, 0, 1);
        chk("d1_rd", 32'(rd_b), 0);
        chk("d1_rc", 32'(rc_b), 1);
        fire(0, 0, 0, 1);
        chk("d2_rd", 32'(rd_b), 2);
        chk("d2_rc", 32'(rc_b), 0);
        fire(0, 0, 0, 1);
        chk("d3_rep", 32'(rep_b),   1);
        chk("d3_rd",  32'(rd_b),    2);
        chk("d3_rsw", 32'(snap_rb), 0);

        // Queue to latest switch collapses at the next event
        fire(0, 0, 1, 0);
        chk("m1_wr", 32'(wr_b), 0);
        fire(0, 0, 1, 0);
        chk("m2_wr", 32'(wr_b), 1);
        @(negedge clk);
        mode_b = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("mtog_rc", 32'(rc_b), 2);
        fire(0, 0, 0, 1);
        chk("mc_rd",   32'(rd_b),   0);
        chk("mc_drop", 32'(drop_b), 2);
        chk("mc_rc",   32'(rc_b),   0);
        chk("mc_wr",   32'(wr_b),   1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
